fifo_access_arb: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_access_arb_starve_cnt.sv | 50 +++++
 rtl/fifo_access_arb.sv | 134 +++++++++++++
 tb/tb_fifo_access_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO access arbiter.
//   arb_state_t : arbiter FSM state encoding
//   PRIO_WR/RD  : round-robin priority values (which side wins a tie)
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    DONE
  } arb_state_t;

  localparam logic PRIO_WR = 1'b0;
  localparam logic PRIO_RD = 1'b1;

endpackage

// File: rtl/fifo_access_arb_starve_cnt.sv
// Per-side starvation counter.
//   clk, rst : clock, synchronous active-high reset
//   req      : client request level
//   ack      : completion pulse for that client
//   timeout  : one-cycle pulse in the cycle the count reaches WAIT_MAX
// The count clears whenever the request is low or being acknowledged and
// otherwise saturates at WAIT_MAX, so a request held past the limit
// produces only one pulse.
module starve_cnt #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CW       = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_PRE = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (!req || ack) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d     = cnt_q + CW'(1);
      // Registered so the pulse lines up with the cycle holding WAIT_MAX.
      timeout_d = (cnt_q == CNT_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/fifo_access_arb.sv
// Arbiter in front of the FIFO pointer controller.
//   clk, rst            : clock, synchronous active-high reset
//   wr_req, rd_req      : client request levels, held until the matching ack
//   full, emp           : controller status flags
//   wr_en, rd_en        : controller feedback (operation performed last edge)
//   wr, rd              : one-cycle strobes to the controller, never together
//   wr_ack, rd_ack      : one-cycle completion pulses to the clients
//   wr_timeout, rd_timeout : starvation pulses after WAIT_MAX pending cycles
//   busy                : high whenever the FSM is not in IDLE
// Each operation walks ISSUE -> WAIT -> DONE -> IDLE; a refusal in WAIT
// returns to IDLE without an ack and without moving the priority.
module fifo_access_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CW       = $clog2(WAIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic rd_req,
  input  logic full,
  input  logic emp,
  input  logic wr_en,
  input  logic rd_en,
  output logic wr,
  output logic rd,
  output logic wr_ack,
  output logic rd_ack,
  output logic wr_timeout,
  output logic rd_timeout,
  output logic busy
);

  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  logic       op_is_wr_q, op_is_wr_d;
  logic       wr_q, wr_d, rd_q, rd_d;
  logic       wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic       busy_q, busy_d;
  logic       ew, er;

  assign ew = wr_req & ~full;
  assign er = rd_req & ~emp;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_is_wr_d = op_is_wr_q;
    // wr_en/rd_en are only looked at in the WAIT states, so X feedback
    // from an unreset controller cannot leak into the FSM.
    unique case (state_q)
      IDLE: begin
        if (ew && (!er || prio_q == PRIO_WR)) state_d = WR_ISSUE;
        else if (er)                          state_d = RD_ISSUE;
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (wr_en) begin
          state_d    = DONE;
          op_is_wr_d = 1'b1;
          prio_d     = PRIO_RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_en) begin
          state_d    = DONE;
          op_is_wr_d = 1'b0;
          prio_d     = PRIO_WR;
        end else begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered decodes of the next state, which makes them
    // identical to decoding the state register one cycle later.
    wr_d     = (state_d == WR_ISSUE);
    rd_d     = (state_d == RD_ISSUE);
    wr_ack_d = (state_d == DONE) &&  op_is_wr_d;
    rd_ack_d = (state_d == DONE) && !op_is_wr_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= PRIO_WR;
      op_is_wr_q <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      op_is_wr_q <= op_is_wr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign wr     = wr_q;
  assign rd     = rd_q;
  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;
  assign busy   = busy_q;

  starve_cnt #(.WAIT_MAX(WAIT_MAX), .CW(CW)) u_wr_starve (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .ack     (wr_ack_q),
    .timeout (wr_timeout)
  );

  starve_cnt #(.WAIT_MAX(WAIT_MAX), .CW(CW)) u_rd_starve (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .ack     (rd_ack_q),
    .timeout (rd_timeout)
  );

endmodule

// File: tb/tb_fifo_access_arb.sv
// Directed bench for fifo_access_arb. Output vector o is
// {wr, rd, wr_ack, rd_ack, wr_timeout, rd_timeout, busy}; each task
// compares it cycle by cycle against hand-derived values. The controller
// feedback is modelled as wr_en = last cycle's (wr & !full), likewise rd_en.
module tb_fifo_access_arb;

  logic clk = 1'b0;
  logic rst, wr_req, rd_req, full, emp, wr_en, rd_en;
  logic wr, rd, wr_ack, rd_ack, wr_timeout, rd_timeout, busy;
  logic [6:0] o;
  logic fb_x;
  int unsigned checks = 0;
  int unsigned errors = 0;

  assign o = {wr, rd, wr_ack, rd_ack, wr_timeout, rd_timeout, busy};

  always #5 clk = ~clk;

  fifo_access_arb #(.WAIT_MAX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .full       (full),
    .emp        (emp),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr         (wr),
    .rd         (rd),
    .wr_ack     (wr_ack),
    .rd_ack     (rd_ack),
    .wr_timeout (wr_timeout),
    .rd_timeout (rd_timeout),
    .busy       (busy)
  );

  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    logic pw, pr, pf, pe;
    pw = wr; pr = rd; pf = full; pe = emp;
    @(posedge clk);
    #1;
    wr_en = fb_x ? 1'bx : (pw & ~pf);
    rd_en = fb_x ? 1'bx : (pr & ~pe);
  endtask

  task automatic apply_reset();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fb_x = 1'b1;
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; full = 1'b0; emp = 1'b0;
    tick();
    tick();
    checks++;
    if (o !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", o, 7'b0000000);
    end
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    // X feedback while idle must not disturb anything.
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (o !== 7'b0000000) begin
        errors++;
        $display("FAIL idle_x_fb k=%0d got=%b exp=%b", k, o, 7'b0000000);
      end
    end
    fb_x = 1'b0;
  endtask

  task automatic test_write_only();
    logic [6:0] e;
    apply_reset();
    emp = 1'b1; full = 1'b0;
    wr_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      case (k)
        1:       e = 7'b1000001;
        2:       e = 7'b0000001;
        3:       e = 7'b0010001;
        default: e = 7'b0000000;
      endcase
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL write_only k=%0d got=%b exp=%b", k, o, e);
      end
      if (k == 3) wr_req = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [6:0] e;
    int pos;
    bit is_w;
    apply_reset();
    emp = 1'b0; full = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      pos  = (k - 1) % 4;
      is_w = (((k - 1) / 4) % 2) == 0;
      case (pos)
        0:       e = is_w ? 7'b1000001 : 7'b0100001;
        1:       e = 7'b0000001;
        2:       e = is_w ? 7'b0010001 : 7'b0001001;
        default: e = 7'b0000000;
      endcase
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL contention k=%0d got=%b exp=%b", k, o, e);
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_full_block();
    logic [6:0] e;
    apply_reset();
    full = 1'b1; emp = 1'b1;
    wr_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      e = (k == 16) ? 7'b0000100 : 7'b0000000;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL full_block k=%0d got=%b exp=%b", k, o, e);
      end
    end
    wr_req = 1'b0; full = 1'b0;
  endtask

  task automatic test_refusal_race();
    logic [6:0] e;
    apply_reset();
    full = 1'b0; emp = 1'b1;
    wr_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      case (k)
        1:       e = 7'b1000001;
        2:       e = 7'b0000001;
        5:       e = 7'b1000001;
        6:       e = 7'b0000001;
        7:       e = 7'b0010001;
        default: e = 7'b0000000;
      endcase
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL refusal_race k=%0d got=%b exp=%b", k, o, e);
      end
      if (k == 1) full = 1'b1;     // controller fills while the strobe is out
      if (k == 4) full = 1'b0;
      if (k == 7) wr_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [6:0] e;
    apply_reset();
    full = 1'b0; emp = 1'b1;
    wr_req = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      case (k)
        1, 5, 24: e = 7'b1000001;
        2, 6, 25: e = 7'b0000001;
        3, 26:    e = 7'b0010001;
        23:       e = 7'b0000010;   // rd count restarted at the reset
        default:  e = 7'b0000000;
      endcase
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_op k=%0d got=%b exp=%b", k, o, e);
      end
      case (k)
        3:  wr_req = 1'b0;                         // prio now favours read
        4:  begin wr_req = 1'b1; rd_req = 1'b1; end
        6:  rst = 1'b1;                            // abort in WR_WAIT
        7:  begin rst = 1'b0; wr_req = 1'b0; end
        23: begin emp = 1'b0; wr_req = 1'b1; end   // tie must go to write
        26: begin wr_req = 1'b0; rd_req = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_empty_drain();
    logic [6:0] e;
    apply_reset();
    full = 1'b0; emp = 1'b1;
    rd_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      case (k)
        6:       e = 7'b0100001;
        7:       e = 7'b0000001;
        8:       e = 7'b0001001;
        default: e = 7'b0000000;
      endcase
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL empty_drain k=%0d got=%b exp=%b", k, o, e);
      end
      if (k == 5) emp = 1'b0;
      if (k == 8) rd_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; full = 1'b0; emp = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; fb_x = 1'b0;
    test_reset();
    test_write_only();
    test_contention();
    test_full_block();
    test_refusal_race();
    test_reset_mid_op();
    test_empty_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
